// File: rtl/uc_pkg.sv
// Shared definitions for the fetch unit and the control unit: widths, fetch
// state encoding and opcodes.
package uc_pkg;

  localparam int PC_W    = 12;
  localparam int INSTR_W = 16;
  localparam int IMEM_AW = 8;

  typedef enum logic [1:0] {
    BOOT_HI = 2'd0,
    BOOT_LO = 2'd1,
    RUN     = 2'd2
  } fetch_state_t;

  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_BEQ = 4'h4;
  localparam logic [3:0] OP_BC  = 4'h5;

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: one synchronous write port and one asynchronous read port.
// Contents are never reset so a warm reload can keep a partial image.
module imem_ram #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: program counter, instruction RAM and byte-stream bootstrap loader.
// Optional boot checksum is enabled by defining FETCH_BOOT_CSUM_EN.
module fetch_unit
  import uc_pkg::*;
#(
  parameter int PC_W    = uc_pkg::PC_W,
  parameter int IMEM_AW = uc_pkg::IMEM_AW,
  parameter int INSTR_W = uc_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               clk_valid,
  output logic               core_valid,
  input  logic               pc_inc,
  input  logic               pc_load,
  input  logic [PC_W-1:0]    pc_next,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    pc,
  output logic               bootstrapping,
  input  logic               boot_req,
  input  logic [7:0]         boot_byte,
  input  logic               boot_valid,
  input  logic               boot_last,
  output logic               boot_ready,
  output logic [IMEM_AW:0]   boot_words
`ifdef FETCH_BOOT_CSUM_EN
  ,
  output logic [7:0]         boot_csum,
  input  logic [7:0]         boot_csum_exp,
  output logic               boot_err
`endif
);

  localparam logic [IMEM_AW-1:0] WR_LAST = '1;

  fetch_state_t        state, state_next;
  logic [IMEM_AW-1:0]  wr_addr;
  logic [7:0]          hi_byte;
  logic                accept;
  logic                lo_accept;
  logic                boot_term;
  logic                boot_ok;
  logic [INSTR_W-1:0]  wr_word;

  // boot_req wins over a byte offered in the same cycle
  assign accept    = boot_valid & boot_ready & ~boot_req;
  assign lo_accept = accept & (state == BOOT_LO);
  assign boot_term = lo_accept & (boot_last | (wr_addr == WR_LAST));
  assign wr_word   = {hi_byte, boot_byte};

`ifdef FETCH_BOOT_CSUM_EN
  logic [7:0] csum_sum;
  assign csum_sum = boot_csum + boot_byte;
  assign boot_ok  = (csum_sum == boot_csum_exp);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      boot_csum <= '0;
      boot_err  <= 1'b0;
    end else begin
      boot_err <= boot_term & ~boot_ok;
      if (boot_req)    boot_csum <= '0;
      else if (accept) boot_csum <= csum_sum;
    end
  end
`else
  assign boot_ok = 1'b1;
`endif

  // state register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= BOOT_HI;
    else         state <= state_next;
  end

  // next-state logic
  always_comb begin
    state_next = state;
    if (boot_req) begin
      state_next = BOOT_HI;
    end else begin
      case (state)
        BOOT_HI: if (accept) state_next = BOOT_LO;
        BOOT_LO: begin
          if (accept) state_next = (boot_term && boot_ok) ? RUN : BOOT_HI;
        end
        RUN:     state_next = RUN;
        default: state_next = BOOT_HI;
      endcase
    end
  end

  // outputs decoded from state
  always_comb begin
    boot_ready    = (state != RUN);
    bootstrapping = (state != RUN);
    core_valid    = clk_valid & (state == RUN);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pc         <= '0;
      wr_addr    <= '0;
      hi_byte    <= '0;
      boot_words <= '0;
    end else if (boot_req) begin
      pc      <= '0;
      wr_addr <= '0;
      hi_byte <= '0;
    end else begin
      if (accept && state == BOOT_HI) hi_byte <= boot_byte;
      if (lo_accept) begin
        // a rejected checksum restarts the image from word 0
        wr_addr <= (boot_term && !boot_ok) ? '0 : wr_addr + IMEM_AW'(1);
        if (boot_term) begin
          boot_words <= {1'b0, wr_addr} + (IMEM_AW+1)'(1);
          pc         <= '0;
        end
      end
      // pc_load only matters in a FETCH cycle (pc_inc high)
      if (core_valid && pc_inc) pc <= pc_load ? pc_next : pc + PC_W'(1);
    end
  end

  imem_ram #(
    .AW (IMEM_AW),
    .DW (INSTR_W)
  ) u_imem (
    .clk   (clk),
    .we    (lo_accept),
    .waddr (wr_addr),
    .wdata (wr_word),
    .raddr (pc[IMEM_AW-1:0]),
    .rdata (instruction)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: bootstrap sequences, a PC vector table
// and randomized run-mode traffic against a simple word-level model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        clk_valid;
  logic        core_valid;
  logic        pc_inc;
  logic        pc_load;
  logic [11:0] pc_next;
  logic [15:0] instruction;
  logic [11:0] pc;
  logic        bootstrapping;
  logic        boot_req;
  logic [7:0]  boot_byte;
  logic        boot_valid;
  logic        boot_last;
  logic        boot_ready;
  logic [8:0]  boot_words;
`ifdef FETCH_BOOT_CSUM_EN
  logic [7:0]  boot_csum;
  logic [7:0]  boot_csum_exp;
  logic        boot_err;
  logic [7:0]  csum_m;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .clk_valid     (clk_valid),
    .core_valid    (core_valid),
    .pc_inc        (pc_inc),
    .pc_load       (pc_load),
    .pc_next       (pc_next),
    .instruction   (instruction),
    .pc            (pc),
    .bootstrapping (bootstrapping),
    .boot_req      (boot_req),
    .boot_byte     (boot_byte),
    .boot_valid    (boot_valid),
    .boot_last     (boot_last),
    .boot_ready    (boot_ready),
    .boot_words    (boot_words)
`ifdef FETCH_BOOT_CSUM_EN
    ,
    .boot_csum     (boot_csum),
    .boot_csum_exp (boot_csum_exp),
    .boot_err      (boot_err)
`endif
  );

  typedef struct {
    logic        cv;
    logic        inc;
    logic        ld;
    logic [11:0] nxt;
    logic [11:0] exp_pc;
    logic        exp_cv;
  } vec_t;

  vec_t        tbl [12];
  logic [15:0] mem_m [256];
  logic [11:0] pc_m;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One boot word as two bytes; the model RAM is updated directly.
  task automatic send_word(input int addr, input logic [15:0] w, input logic last);
    boot_valid = 1'b1;
    boot_byte  = w[15:8];
    boot_last  = 1'b0;
`ifdef FETCH_BOOT_CSUM_EN
    csum_m = csum_m + w[15:8];
`endif
    tick();
    boot_byte = w[7:0];
    boot_last = last;
`ifdef FETCH_BOOT_CSUM_EN
    csum_m = csum_m + w[7:0];
    boot_csum_exp = csum_m;
`endif
    tick();
    boot_valid = 1'b0;
    boot_last  = 1'b0;
    mem_m[addr] = w;
    $display("boot word[%0d] = %04h last=%0b", addr, w, last);
  endtask

  task automatic pulse_boot_req();
    boot_req = 1'b1;
    tick();
    boot_req = 1'b0;
`ifdef FETCH_BOOT_CSUM_EN
    csum_m = 8'h00;
`endif
  endtask

  task automatic fetch_step(input logic ld, input logic [11:0] nxt);
    pc_inc  = 1'b1;
    pc_load = ld;
    pc_next = nxt;
    tick();
    pc_inc  = 1'b0;
    pc_load = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    arst_n = 1'b0; clk_valid = 1'b1; pc_inc = 1'b0; pc_load = 1'b0; pc_next = '0;
    boot_req = 1'b0; boot_byte = '0; boot_valid = 1'b0; boot_last = 1'b0;
`ifdef FETCH_BOOT_CSUM_EN
    csum_m = 8'h00; boot_csum_exp = 8'h00;
`endif
    #12;
    chk("rst_bootstrapping", bootstrapping, 1'b1);
    chk("rst_boot_ready", boot_ready, 1'b1);
    chk("rst_core_valid", core_valid, 1'b0);
    chk("rst_pc", pc, 12'h000);
    chk("rst_boot_words", boot_words, 9'd0);
    @(negedge clk);
    arst_n = 1'b1;
    tick();

    // short boot ending on boot_last
    send_word(0, 16'h1234, 1'b0);
    send_word(1, 16'h5678, 1'b1);
    chk("boot4_bootstrapping", bootstrapping, 1'b0);
    chk("boot4_boot_ready", boot_ready, 1'b0);
    chk("boot4_core_valid", core_valid, 1'b1);
    chk("boot4_pc", pc, 12'h000);
    chk("boot4_words", boot_words, 9'd2);
    chk("boot4_instr0", instruction, 16'h1234);
    fetch_step(1'b0, 12'h000);
    chk("boot4_pc1", pc, 12'h001);
    chk("boot4_instr1", instruction, 16'h5678);

    // warm reload from RUN, with a fetch offered in the same cycle
    pc_inc = 1'b1;
    pulse_boot_req();
    pc_inc = 1'b0;
    chk("req_bootstrapping", bootstrapping, 1'b1);
    chk("req_core_valid", core_valid, 1'b0);
    chk("req_pc", pc, 12'h000);

    // pending high byte, then boot_req colliding with a byte: both discarded
    boot_valid = 1'b1; boot_byte = 8'hAA;
    tick();
    boot_req = 1'b1; boot_byte = 8'hBB;
    tick();
    boot_req = 1'b0; boot_valid = 1'b0;
`ifdef FETCH_BOOT_CSUM_EN
    csum_m = 8'h00;
`endif
    chk("drop_bootstrapping", bootstrapping, 1'b1);

    // full RAM terminates the boot without boot_last
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      send_word(i, w, 1'b0);
      if (i == 254) chk("full_still_booting", bootstrapping, 1'b1);
    end
    chk("full_bootstrapping", bootstrapping, 1'b0);
    chk("full_words", boot_words, 9'd256);
    chk("full_pc", pc, 12'h000);
    chk("full_instr0", instruction, mem_m[0]);

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 12'h000, 12'h001, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 12'h000, 12'h002, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 12'h000, 12'h003, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 12'h000, 12'h003, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 12'h0A0, 12'h003, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 12'h000, 12'h004, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 12'h000, 12'h005, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 12'h0A0, 12'h0A0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 12'h055, 12'h0A0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 12'hFFF, 12'hFFF, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 12'h105, 12'h105, 1'b1};
    for (int i = 0; i < 12; i++) begin
      clk_valid = tbl[i].cv; pc_inc = tbl[i].inc; pc_load = tbl[i].ld; pc_next = tbl[i].nxt;
      #1;
      chk("tbl_core_valid", core_valid, tbl[i].exp_cv);
      tick();
      chk("tbl_pc", pc, tbl[i].exp_pc);
      chk("tbl_instr", instruction, mem_m[tbl[i].exp_pc[7:0]]);
      $display("vec %0d cv=%0b inc=%0b ld=%0b nxt=%03h -> pc=%03h instr=%04h",
               i, tbl[i].cv, tbl[i].inc, tbl[i].ld, tbl[i].nxt, pc, instruction);
    end

    // randomized run-mode traffic against the PC model
    pc_m = 12'h105;
    for (int i = 0; i < 400; i++) begin
      clk_valid = ($urandom_range(0, 3) != 0);
      pc_inc    = 1'($urandom);
      pc_load   = ($urandom_range(0, 3) == 0);
      pc_next   = ($urandom_range(0, 7) == 0) ? 12'hFFE : 12'($urandom);
      #1;
      chk("rnd_core_valid", core_valid, clk_valid);
      tick();
      if (clk_valid && pc_inc) pc_m = pc_load ? pc_next : pc_m + 12'd1;
      chk("rnd_pc", pc, pc_m);
      chk("rnd_instr", instruction, mem_m[pc_m[7:0]]);
    end
    $display("random run: 400 cycles, final pc=%03h", pc);
    clk_valid = 1'b1; pc_inc = 1'b0; pc_load = 1'b0;

    // reset mid-boot keeps partial contents and restarts at word 0
    pulse_boot_req();
    send_word(0, 16'hC0DE, 1'b0);
    send_word(1, 16'hBEEF, 1'b0);
    boot_valid = 1'b1; boot_byte = 8'hEE;
    tick();
    boot_valid = 1'b0;
    arst_n = 1'b0;
    #2;
    chk("midrst_bootstrapping", bootstrapping, 1'b1);
    chk("midrst_pc", pc, 12'h000);
    chk("midrst_words", boot_words, 9'd0);
    @(negedge clk);
    arst_n = 1'b1;
`ifdef FETCH_BOOT_CSUM_EN
    csum_m = 8'h00;
`endif
    tick();
    send_word(0, 16'h4321, 1'b1);
    chk("midrst_words1", boot_words, 9'd1);
    chk("midrst_instr0", instruction, 16'h4321);
    fetch_step(1'b1, 12'h001);
    chk("midrst_keep1", instruction, 16'hBEEF);
    fetch_step(1'b1, 12'h002);
    chk("midrst_keep2", instruction, mem_m[2]);

`ifdef FETCH_BOOT_CSUM_EN
    pulse_boot_req();
    boot_valid = 1'b1; boot_byte = 8'h01;
    tick();
    boot_byte = 8'h02; boot_last = 1'b1; boot_csum_exp = 8'h04;
    tick();
    boot_valid = 1'b0; boot_last = 1'b0;
    chk("csum_bad_err", boot_err, 1'b1);
    chk("csum_bad_bootstrapping", bootstrapping, 1'b1);
    tick();
    chk("csum_bad_err_pulse", boot_err, 1'b0);
    pulse_boot_req();
    send_word(0, 16'h0102, 1'b1);
    chk("csum_ok_exp", boot_csum_exp, 8'h03);
    chk("csum_ok_sum", boot_csum, 8'h03);
    chk("csum_ok_err", boot_err, 1'b0);
    chk("csum_ok_bootstrapping", bootstrapping, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
